sync_fifo_wr_arbiter: RTL and testbench
=======================================

// Module: sync_fifo_wr_arbiter
// PURPOSE
//  Shares the write port of one sync_fifo_core among NUM_REQ producers.
//  Round-robin arbitration with per-requester valid/ready handshake; tags each beat with its source ID.
//  Sits directly in front of sync_fifo_core wen/wdata/wfull; read side of the FIFO is untouched.
// PARAMETERS
//  NUM_REQ     4    number of requesters, 2..16
//  DATA_WIDTH  8    payload width per requester
//  ID_WIDTH    2    source-tag width, must be >= $clog2(NUM_REQ), min 1
//  CNT_WIDTH   16   width of accepted-beat counter
// PORTS
//  clk         in   1                      clock, all state on posedge
//  reset       in   1                      synchronous, active-high
//  req_valid   in   NUM_REQ                per-requester beat valid
//  req_data    in   NUM_REQ*DATA_WIDTH     requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_last    in   NUM_REQ                last beat of packet (used only with FIFO_ARB_PKT_LOCK_EN)
//  req_ready   out  NUM_REQ                beat accepted when req_valid[i] & req_ready[i]
//  fifo_wen    out  1                      to sync_fifo_core wen
//  fifo_wdata  out  ID_WIDTH+DATA_WIDTH    {grant_id, payload}, to sync_fifo_core wdata
//  fifo_wfull  in   1                      from sync_fifo_core wfull
//  grant_id    out  ID_WIDTH               index of current grantee (valid when fifo_wen)
//  beat_count  out  CNT_WIDTH              total accepted beats, wraps modulo 2**CNT_WIDTH
// BEHAVIOUR
//  - State: rr_ptr (ID_WIDTH, highest-priority index), lock_vld, lock_id, beat_count.
//  - Reset (sync): rr_ptr=0, lock_vld=0, lock_id=0, beat_count=0; while reset=1 req_ready=0, fifo_wen=0.
//  - Grant (combinational, zero latency): first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    No valid -> no grant, grant_id=rr_ptr, fifo_wen=0, fifo_wdata holds last-granted value is NOT required (don't care).
//  - req_ready[i] = granted(i) & ~fifo_wfull & ~reset; exactly one-hot or zero.
//  - fifo_wen = |(req_valid & req_ready); fifo_wdata = {grant_id, req_data[grant_id]}.
//  - Never writes when fifo_wfull=1; stalled requester keeps valid, data must be held stable by producer.
//  - On accept (fifo_wen=1): rr_ptr <= (grant_id+1) mod NUM_REQ; beat_count <= beat_count+1 (wrap).
//  - On no accept: rr_ptr unchanged; grant may move to another requester if the grantee drops valid.
//  - Fairness: a continuously valid requester is accepted within NUM_REQ accepted beats.
//  - Index arithmetic: wrap via explicit compare to NUM_REQ-1, not power-of-2 truncation (NUM_REQ may be 3,5,...).
//  - Reset mid-transfer: beat in flight that cycle is not written; all state returns to reset values next cycle.
// CONFIGURATION
//  FIFO_ARB_PKT_LOCK_EN defined:
//   - FSM ARB (lock_vld=0) / LOCK (lock_vld=1).
//   - ARB: grant as above; accept with req_last=0 -> LOCK, lock_id<=grant_id; accept with req_last=1 -> stay ARB.
//   - LOCK: grant forced to lock_id regardless of other valids; lock_id with valid=0 -> no grant, fifo_wen=0.
//   - LOCK: accept with req_last[lock_id]=1 -> ARB, rr_ptr<=lock_id+1 mod NUM_REQ.
//   - LOCK: rr_ptr not advanced on non-last beats; packets from different requesters never interleave in FIFO.
//  FIFO_ARB_PKT_LOCK_EN undefined: req_last ignored, lock_vld/lock_id tied 0, per-beat round-robin only.
// TESTING
//  1 Reset: assert reset 2 cycles with all req_valid=4'hF -> req_ready=0, fifo_wen=0, beat_count=0, rr_ptr=0.
//  2 All valid=4'hF, wfull=0, 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3; beat_count=8; fifo_wdata={id,data}.
//  3 req_valid=4'b1010, rr_ptr=0 -> grant 1 then 3 then 1; requesters 0,2 never readied.
//  4 Full: wfull=1 for 3 cycles with valid=4'hF -> req_ready=0, fifo_wen=0, rr_ptr and beat_count frozen; wfull=0 -> resume at same grant_id.
//  5 Wrap: preload to beat_count=16'hFFFF via 65535 accepts, one more accept -> beat_count=0.
//  6 PKT_LOCK_EN: req 2 sends 3-beat packet (last on beat 3) while req 0,1,3 valid -> three consecutive grants to 2,
//    then next grant 3; deassert req 2 valid mid-packet -> fifo_wen=0, no other grant until req 2 finishes.

Source files
------------

// File: rtl/sync_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// sync_fifo_wr_arbiter
//   Shares the write port of one sync_fifo_core among NUM_REQ producers.
//   Each cycle, round-robin arbitration grants one valid requester, with zero
//   latency. An accepted beat is written as {source id, payload}. The read
//   side of the FIFO does not pass through this block.
//
//   Optional feature (macro FIFO_ARB_PKT_LOCK_EN): packet lock. After the
//   first beat of a packet with req_last=0, the grant stays with that
//   requester until it delivers a beat with req_last=1. Packets from
//   different requesters therefore never interleave in the FIFO. Without
//   the macro, req_last is ignored and arbitration is per beat.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   req_valid    per-requester beat valid
//   req_data     requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last     last beat of packet (packet-lock build only)
//   req_ready    one-hot or zero; a beat is accepted on valid & ready
//   fifo_wen     write enable to sync_fifo_core
//   fifo_wdata   {grant_id, payload} to sync_fifo_core
//   fifo_wfull   full flag from sync_fifo_core
//   grant_id     current grantee (rr_ptr when nothing is valid)
//   beat_count   accepted beats, wraps modulo 2**CNT_WIDTH
// ---------------------------------------------------------------------------
module sync_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           fifo_wen,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wdata,
  input  logic                           fifo_wfull,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic [CNT_WIDTH-1:0]           beat_count
);

  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   gnt;
  logic                  gnt_vld;
  logic [ID_WIDTH-1:0]   rr_nxt;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  gnt_last;
  logic                  rr_adv;

  // Round-robin scan starting at rr_ptr. Wrap uses an explicit compare, so a
  // NUM_REQ that is not a power of two (3, 5, ...) still rotates correctly.
  logic [ID_WIDTH-1:0] rr_gnt;
  logic                rr_gnt_vld;
  always_comb begin
    int  idx;
    logic hit;
    rr_gnt     = rr_ptr;
    rr_gnt_vld = 1'b0;
    idx        = 0;
    hit        = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx > NUM_REQ - 1) idx = idx - NUM_REQ;
      hit = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
        if (i == idx) hit = req_valid[i];
      if (!rr_gnt_vld && hit) begin
        rr_gnt_vld = 1'b1;
        rr_gnt     = ID_WIDTH'(idx);
      end
    end
  end

`ifdef FIFO_ARB_PKT_LOCK_EN
  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;
  state_t              state;
  logic [ID_WIDTH-1:0] lock_id;
  logic                lock_vld;
  logic                lock_hit;

  assign lock_vld = (state == LOCK);

  always_comb begin
    lock_hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (int'(lock_id) == i) lock_hit = req_valid[i];
  end

  // While locked, the lock holder owns the port. If the holder drops valid,
  // the port idles rather than letting another requester in mid-packet.
  always_comb begin
    if (lock_vld) begin
      gnt     = lock_id;
      gnt_vld = lock_hit;
    end else begin
      gnt     = rr_gnt;
      gnt_vld = rr_gnt_vld;
    end
  end

  // Inside a packet the pointer already sits at lock_id+1 from the first
  // beat, so it only moves again on the closing beat.
  assign rr_adv = !lock_vld || gnt_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB;
      lock_id <= '0;
    end else if (fifo_wen) begin
      case (state)
        ARB:  if (!gnt_last) begin
                state   <= LOCK;
                lock_id <= gnt;
              end
        LOCK: if (gnt_last) state <= ARB;
        default: state <= ARB;
      endcase
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign gnt         = rr_gnt;
  assign gnt_vld     = rr_gnt_vld;
  assign rr_adv      = 1'b1;
`endif

  // Payload and last-flag mux for the grantee.
  always_comb begin
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (int'(gnt) == i) begin
        gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_last = req_last[i];
      end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = gnt_vld && (int'(gnt) == i) && !fifo_wfull && !reset;
  end

  assign fifo_wen   = |(req_valid & req_ready);
  assign fifo_wdata = {gnt, gnt_data};
  assign grant_id   = gnt;
  assign rr_nxt     = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + ID_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      beat_count <= '0;
    end else if (fifo_wen) begin
      beat_count <= beat_count + CNT_WIDTH'(1);
      if (rr_adv) rr_ptr <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
module tb_sync_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready;
  logic              fifo_wen;
  logic [IW+DW-1:0]  fifo_wdata;
  logic              fifo_wfull;
  logic [IW-1:0]     grant_id;
  logic [CW-1:0]     beat_count;

  int checks   = 0;
  int failures = 0;

  sync_fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wen(fifo_wen),
    .fifo_wdata(fifo_wdata), .fifo_wfull(fifo_wfull), .grant_id(grant_id),
    .beat_count(beat_count));

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    logic          wfull;
    logic          rst;
    logic [N-1:0]  ready;
    logic          wen;
    logic [IW-1:0] gid;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [N-1:0] v, input logic wf, input logic r,
                     input logic [N-1:0] rdy, input logic w, input int g, input int c);
    vec_t t;
    t.valid = v; t.last = '1; t.wfull = wf; t.rst = r;
    t.ready = rdy; t.wen = w; t.gid = IW'(g); t.cnt = CW'(c);
    vecs.push_back(t);
  endtask

  task automatic set_fixed_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(8'hA0 + i);
  endtask

  // Drive one cycle from a vector, check mid-cycle, then clock it in.
  task automatic apply(input vec_t t, input string tag);
    req_valid = t.valid; req_last = t.last; fifo_wfull = t.wfull; reset = t.rst;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(t.ready));
    chk({tag, ".wen"},   32'(fifo_wen),  32'(t.wen));
    chk({tag, ".gid"},   32'(grant_id),  32'(t.gid));
    chk({tag, ".cnt"},   32'(beat_count), 32'(t.cnt));
    if (t.wen) chk({tag, ".wdata"}, 32'(fifo_wdata), 32'({t.gid, DW'(8'hA0 + t.gid)}));
    @(posedge clk); #1;
  endtask

  // Reference model: plain modular arithmetic on integers.
  int m_rr, m_cnt, m_lock, m_lid;

  task automatic model_cycle(input logic [N-1:0] v, input logic [N-1:0] l,
                             input logic wf, input logic r);
    int g; int gv; logic [N-1:0] er; logic ew;
    req_valid = v; req_last = l; fifo_wfull = wf; reset = r;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    #1;
    g = m_rr; gv = 0;
    if (m_lock != 0) begin
      g = m_lid; gv = v[m_lid];
    end else begin
      for (int k = 0; k < N; k++)
        if (!gv && v[(m_rr + k) % N]) begin g = (m_rr + k) % N; gv = 1; end
    end
    er = (gv && !wf && !r) ? N'(1 << g) : '0;
    ew = (er != 0);
    chk("rnd.ready", 32'(req_ready), 32'(er));
    chk("rnd.wen",   32'(fifo_wen),  32'(ew));
    chk("rnd.cnt",   32'(beat_count), 32'(m_cnt));
    if (ew) begin
      chk("rnd.gid",   32'(grant_id), 32'(g));
      chk("rnd.wdata", 32'(fifo_wdata), 32'({IW'(g), req_data[g*DW +: DW]}));
    end else if (v == 0 && m_lock == 0) begin
      chk("rnd.idle_gid", 32'(grant_id), 32'(m_rr));
    end
    @(posedge clk); #1;
    if (r) begin
      m_rr = 0; m_cnt = 0; m_lock = 0; m_lid = 0;
    end else if (ew) begin
      m_cnt = (m_cnt + 1) % 65536;
`ifdef FIFO_ARB_PKT_LOCK_EN
      if (m_lock == 0) begin
        if (!l[g]) begin m_lock = 1; m_lid = g; end
        m_rr = (g + 1) % N;
      end else if (l[g]) begin
        m_lock = 0; m_rr = (g + 1) % N;
      end
`else
      m_rr = (g + 1) % N;
`endif
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_last = '1; fifo_wfull = 1'b0; req_data = '0;
    set_fixed_data();

    // Reset with everything valid, then 8 cycles of full contention.
    add(4'hF, 0, 1, 4'h0, 0, 0, 0);
    add(4'hF, 0, 1, 4'h0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(4'hF, 0, 0, N'(1 << (i % 4)), 1, i % 4, i);
    add(4'h0, 0, 0, 4'h0, 0, 0, 8);
    // Sparse requesters 1 and 3 only.
    add(4'hA, 0, 0, 4'h2, 1, 1, 8);
    add(4'hA, 0, 0, 4'h8, 1, 3, 9);
    add(4'hA, 0, 0, 4'h2, 1, 1, 10);
    // FIFO full: everything frozen, then resume at the same grantee.
    add(4'hF, 1, 0, 4'h0, 0, 2, 11);
    add(4'hF, 1, 0, 4'h0, 0, 2, 11);
    add(4'hF, 1, 0, 4'h0, 0, 2, 11);
    add(4'hF, 0, 0, 4'h4, 1, 2, 11);
    add(4'h0, 0, 0, 4'h0, 0, 3, 12);
    // Reset mid-transfer: the beat is dropped and state returns to reset values.
    add(4'hF, 0, 1, 4'h0, 0, 3, 12);
    add(4'h0, 0, 0, 4'h0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Counter wrap: 65535 accepts reach FFFF, one more wraps to 0.
    reset = 1'b1; req_valid = '0; @(posedge clk); #1;
    reset = 1'b0; req_valid = 4'h1;
    for (int i = 0; i < 65535; i++) begin @(posedge clk); #1; end
    chk("wrap.ffff", 32'(beat_count), 32'hFFFF);
    @(posedge clk); #1;
    chk("wrap.zero", 32'(beat_count), 32'h0);
    req_valid = '0;

`ifdef FIFO_ARB_PKT_LOCK_EN
    begin
      vec_t t;
      reset = 1'b1; @(posedge clk); #1;
      // One single-beat packet from requester 1 moves rr_ptr to 2.
      t = '{4'h2, 4'hF, 0, 0, 4'h2, 1, 2'd1, 16'd0}; apply(t, "lk.pre");
      t = '{4'hF, 4'h0, 0, 0, 4'h4, 1, 2'd2, 16'd1}; apply(t, "lk.b1");
      t = '{4'hF, 4'h0, 0, 0, 4'h4, 1, 2'd2, 16'd2}; apply(t, "lk.b2");
      t = '{4'hB, 4'h0, 0, 0, 4'h0, 0, 2'd2, 16'd3}; apply(t, "lk.hole");
      t = '{4'hF, 4'h4, 0, 0, 4'h4, 1, 2'd2, 16'd3}; apply(t, "lk.b3");
      t = '{4'hF, 4'hF, 0, 0, 4'h8, 1, 2'd3, 16'd4}; apply(t, "lk.next");
    end
`endif

    // Randomized run against the reference model, starting from reset.
    m_rr = 0; m_cnt = 0; m_lock = 0; m_lid = 0;
    model_cycle(4'hF, 4'hF, 1'b0, 1'b1);
    for (int c = 0; c < 3000; c++)
      model_cycle(N'($urandom), N'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 49) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
